// File: rtl/psum_accumulator_pkg.sv
// Shared widths, int8 limits and saturating arithmetic helpers for the
// partial-sum accumulator and its requantizer lanes.
package psum_accumulator_pkg;

    localparam int LANES   = 8;
    localparam int PSUM_W  = 21;
    localparam int ACC_W   = 32;
    localparam int OUT_W   = 8;
    localparam int CNT_W   = 8;
    localparam int SHIFT_W = 5;

    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;

    // Two's-complement add that clamps to the ACC_W range instead of wrapping.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1])
            sat_add = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            sat_add = s[ACC_W-1:0];
    endfunction

    function automatic logic [ACC_W-1:0] sext_psum(input logic [PSUM_W-1:0] p);
        sext_psum = {{(ACC_W-PSUM_W){p[PSUM_W-1]}}, p};
    endfunction

endpackage

// File: rtl/psum_accumulator_requant_lane.sv
// Combinational requantizer for one lane: round-half-up shift, optional ReLU,
// clamp to int8.
module requant_lane
    import psum_accumulator_pkg::*;
(
    input  logic [ACC_W-1:0]   x,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               relu_en,
    output logic [OUT_W-1:0]   q
);

    localparam logic [ACC_W-1:0]        ACC_ONE = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic signed [ACC_W-1:0] Q_MAX   = ACC_W'(INT8_MAX);
    localparam logic signed [ACC_W-1:0] Q_MIN   = ACC_W'(INT8_MIN);

    logic [ACC_W-1:0]        bias;
    logic signed [ACC_W-1:0] rounded;
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] clipped;

    always_comb begin
        bias = '0;
        if (shift != '0)
            bias = ACC_ONE << (shift - SHIFT_W'(1));
        // Rounding bias saturates so a value near the top cannot flip sign.
        rounded = $signed(sat_add(x, bias));
        shifted = rounded >>> shift;
        clipped = shifted;
        if (relu_en && (shifted < 0))
            clipped = '0;
        else if (shifted > Q_MAX)
            clipped = Q_MAX;
        else if (shifted < Q_MIN)
            clipped = Q_MIN;
        q = clipped[OUT_W-1:0];
    end

endmodule

// File: rtl/psum_accumulator.sv
// Multi-beat per-lane partial-sum accumulator with int8 requantization and a
// valid/ready output register toward the output-feature-map writer.
module psum_accumulator
    import psum_accumulator_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [LANES*PSUM_W-1:0]  psum_in,
    input  logic                     psum_valid,
    output logic                     psum_ready,
    input  logic [CNT_W-1:0]         acc_len,
    input  logic [SHIFT_W-1:0]       shift,
    input  logic                     relu_en,
    input  logic                     acc_clear,
    output logic [LANES*OUT_W-1:0]   q_dout,
    output logic                     q_valid,
    input  logic                     q_ready,
    output logic                     busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   len_reg;
    logic [SHIFT_W-1:0] shift_reg;
    logic               relu_reg;
    logic               q_valid_reg;
    logic [ACC_W-1:0]   acc_reg  [LANES];
    logic [OUT_W-1:0]   q_reg    [LANES];
    logic [ACC_W-1:0]   sum_next [LANES];
    logic [OUT_W-1:0]   q_next   [LANES];

    logic               first_beat;
    logic [CNT_W-1:0]   live_len;
    logic               is_last;
    logic [SHIFT_W-1:0] cur_shift;
    logic               cur_relu;
    logic               accept;

    // On the first beat the config has not been latched yet, so use the live inputs.
    assign first_beat = (cnt_reg == '0);
    assign live_len   = (acc_len == '0) ? CNT_ONE : acc_len;
    assign is_last    = first_beat ? (live_len == CNT_ONE) : (cnt_reg == len_reg - CNT_ONE);
    assign cur_shift  = first_beat ? shift   : shift_reg;
    assign cur_relu   = first_beat ? relu_en : relu_reg;

    assign psum_ready = !acc_clear && !(q_valid_reg && !q_ready && is_last);
    assign accept     = psum_valid && psum_ready;
    assign busy       = !first_beat;
    assign q_valid    = q_valid_reg;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [ACC_W-1:0] ext;
            assign ext          = sext_psum(psum_in[gi*PSUM_W +: PSUM_W]);
            assign sum_next[gi] = first_beat ? ext : sat_add(acc_reg[gi], ext);

            requant_lane u_requant (
                .x       (sum_next[gi]),
                .shift   (cur_shift),
                .relu_en (cur_relu),
                .q       (q_next[gi])
            );

            assign q_dout[gi*OUT_W +: OUT_W] = q_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg     <= '0;
            len_reg     <= '0;
            shift_reg   <= '0;
            relu_reg    <= 1'b0;
            q_valid_reg <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                acc_reg[i] <= '0;
                q_reg[i]   <= '0;
            end
        end else begin
            if (acc_clear) begin
                cnt_reg <= '0;
                for (int i = 0; i < LANES; i++)
                    acc_reg[i] <= '0;
            end else if (accept) begin
                if (first_beat) begin
                    len_reg   <= live_len;
                    shift_reg <= shift;
                    relu_reg  <= relu_en;
                end
                cnt_reg <= is_last ? '0 : cnt_reg + CNT_ONE;
                for (int i = 0; i < LANES; i++)
                    acc_reg[i] <= sum_next[i];
            end

            // A new result loaded on a consume edge keeps q_valid high without a bubble.
            if (accept && is_last) begin
                q_valid_reg <= 1'b1;
                for (int i = 0; i < LANES; i++)
                    q_reg[i] <= q_next[i];
            end else if (q_valid_reg && q_ready) begin
                q_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed self-checking bench for psum_accumulator; inputs are driven and
// outputs sampled 1-2 time units after the rising edge.
module tb_psum_accumulator;
    import psum_accumulator_pkg::*;

    logic                    clk;
    logic                    reset;
    logic [LANES*PSUM_W-1:0] psum_in;
    logic                    psum_valid;
    logic                    psum_ready;
    logic [CNT_W-1:0]        acc_len;
    logic [SHIFT_W-1:0]      shift;
    logic                    relu_en;
    logic                    acc_clear;
    logic [LANES*OUT_W-1:0]  q_dout;
    logic                    q_valid;
    logic                    q_ready;
    logic                    busy;

    int tests = 0;
    int fails = 0;

    psum_accumulator dut (
        .clk        (clk),
        .reset      (reset),
        .psum_in    (psum_in),
        .psum_valid (psum_valid),
        .psum_ready (psum_ready),
        .acc_len    (acc_len),
        .shift      (shift),
        .relu_en    (relu_en),
        .acc_clear  (acc_clear),
        .q_dout     (q_dout),
        .q_valid    (q_valid),
        .q_ready    (q_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] qlane(input int i);
        return q_dout[i*OUT_W +: OUT_W];
    endfunction

    task automatic set_lane(input int i, input int v);
        psum_in[i*PSUM_W +: PSUM_W] = PSUM_W'(v);
    endtask

    task automatic setup(input int len, input int sh, input bit relu, input bit rdy);
        psum_in = '0;
        acc_len = CNT_W'(len);
        shift   = SHIFT_W'(sh);
        relu_en = relu;
        q_ready = rdy;
    endtask

    // Present a beat and hold it until accepted (bounded); ends 1 unit after the accept edge.
    task automatic push_beat();
        int n = 0;
        psum_valid = 1'b1;
        #1;
        while (!psum_ready && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        tests++;
        if (!psum_ready) begin
            $display("FAIL push_beat_timeout: psum_ready=%0b after %0d cycles, required 1", psum_ready, n);
            fails++;
        end
        @(posedge clk); #1;
        psum_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; psum_valid = 1'b0; acc_clear = 1'b0;
        setup(1, 0, 1'b0, 1'b1);
        #2 reset = 1'b0;
        #1;
        tests++;
        if (q_valid !== 1'b0) begin $display("FAIL reset_q_valid: got %0b required 0", q_valid); fails++; end
        tests++;
        if (q_dout !== '0) begin $display("FAIL reset_q_dout: got %h required 0", q_dout); fails++; end
        tests++;
        if (busy !== 1'b0) begin $display("FAIL reset_busy: got %0b required 0", busy); fails++; end
        tests++;
        if (psum_ready !== 1'b1) begin $display("FAIL reset_psum_ready: got %0b required 1", psum_ready); fails++; end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_beat();
        setup(1, 0, 1'b0, 1'b1);
        set_lane(0, 5);
        set_lane(7, -3);
        push_beat();
        tests++;
        if (q_valid !== 1'b1) begin $display("FAIL single_q_valid: got %0b required 1", q_valid); fails++; end
        tests++;
        if (qlane(0) !== 8'd5) begin $display("FAIL single_lane0: got %h required 05", qlane(0)); fails++; end
        tests++;
        if (qlane(7) !== 8'hFD) begin $display("FAIL single_lane7: got %h required fd", qlane(7)); fails++; end
        tests++;
        if (busy !== 1'b0) begin $display("FAIL single_busy: got %0b required 0", busy); fails++; end
        @(posedge clk); #1;
        tests++;
        if (q_valid !== 1'b0) begin $display("FAIL single_q_drop: got %0b required 0", q_valid); fails++; end
    endtask

    task automatic test_multi_beat();
        int vals [4] = '{100, 200, 300, 400};
        int busy_cycles = 0;
        int valid_cycles = 0;
        setup(4, 4, 1'b0, 1'b1);
        for (int b = 0; b < 4; b++) begin
            set_lane(0, vals[b]);
            push_beat();
            if (b == 0) begin
                // Mid-job config changes must not take effect.
                acc_len = 8'd2;
                shift   = 5'd0;
            end
            if (busy) busy_cycles++;
            if (q_valid) valid_cycles++;
        end
        tests++;
        if (busy_cycles != 3) begin $display("FAIL multi_busy_cycles: got %0d required 3", busy_cycles); fails++; end
        tests++;
        if (qlane(0) !== 8'd63) begin $display("FAIL multi_lane0: got %h required 3f", qlane(0)); fails++; end
        @(posedge clk); #1;
        if (q_valid) valid_cycles++;
        tests++;
        if (valid_cycles != 1) begin $display("FAIL multi_valid_count: got %0d required 1", valid_cycles); fails++; end
    endtask

    task automatic test_rounding();
        logic [OUT_W-1:0] exp_q [LANES] = '{8'h01, 8'h00, 8'h02, 8'hFF, 8'hFE, 8'h3F, 8'h7F, 8'h80};
        int vin [LANES] = '{8, -8, 24, -24, -25, 1000, 5000, -5000};
        setup(0, 4, 1'b0, 1'b1);
        for (int i = 0; i < LANES; i++) set_lane(i, vin[i]);
        push_beat();
        tests++;
        if (q_valid !== 1'b1) begin $display("FAIL round_len0_q_valid: got %0b required 1", q_valid); fails++; end
        for (int i = 0; i < LANES; i++) begin
            tests++;
            if (qlane(i) !== exp_q[i]) begin
                $display("FAIL round_lane%0d: got %h required %h", i, qlane(i), exp_q[i]); fails++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sat_relu();
        for (int r = 1; r >= 0; r--) begin
            setup(2, 0, r[0], 1'b1);
            set_lane(1, -1000000);
            set_lane(2, 1048575);
            set_lane(3, -5);
            push_beat();
            push_beat();
            tests++;
            if (qlane(1) !== (r == 1 ? 8'h00 : 8'h80)) begin
                $display("FAIL sat_lane1_relu%0d: got %h required %h", r, qlane(1), (r == 1 ? 8'h00 : 8'h80)); fails++;
            end
            tests++;
            if (qlane(2) !== 8'h7F) begin $display("FAIL sat_lane2_relu%0d: got %h required 7f", r, qlane(2)); fails++; end
            tests++;
            if (qlane(3) !== (r == 1 ? 8'h00 : 8'hF6)) begin
                $display("FAIL sat_lane3_relu%0d: got %h required %h", r, qlane(3), (r == 1 ? 8'h00 : 8'hF6)); fails++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        setup(1, 0, 1'b0, 1'b1);
        set_lane(0, 3);
        push_beat();
        tests++;
        if (qlane(0) !== 8'd3 || q_valid !== 1'b1) begin
            $display("FAIL b2b_first: got %h/%0b required 03/1", qlane(0), q_valid); fails++;
        end
        set_lane(0, 4);
        push_beat();
        tests++;
        if (qlane(0) !== 8'd4 || q_valid !== 1'b1) begin
            $display("FAIL b2b_second: got %h/%0b required 04/1", qlane(0), q_valid); fails++;
        end
        @(posedge clk); #1;
        tests++;
        if (q_valid !== 1'b0) begin $display("FAIL b2b_drop: got %0b required 0", q_valid); fails++; end
    endtask

    task automatic test_backpressure();
        setup(1, 0, 1'b0, 1'b0);
        set_lane(0, 11);
        push_beat();
        @(posedge clk); #1;
        tests++;
        if (q_valid !== 1'b1 || qlane(0) !== 8'd11) begin
            $display("FAIL bp_hold_old: got %h/%0b required 0b/1", qlane(0), q_valid); fails++;
        end
        acc_len = 8'd2;
        set_lane(0, 20);
        push_beat();
        tests++;
        if (busy !== 1'b1 || qlane(0) !== 8'd11) begin
            $display("FAIL bp_first_beat: busy=%0b lane0=%h required 1/0b", busy, qlane(0)); fails++;
        end
        set_lane(0, 30);
        psum_valid = 1'b1;
        #1;
        tests++;
        if (psum_ready !== 1'b0) begin $display("FAIL bp_last_stalled: got %0b required 0", psum_ready); fails++; end
        @(posedge clk); #2;
        tests++;
        if (psum_ready !== 1'b0 || q_valid !== 1'b1 || qlane(0) !== 8'd11) begin
            $display("FAIL bp_still_stalled: ready=%0b valid=%0b lane0=%h required 0/1/0b", psum_ready, q_valid, qlane(0)); fails++;
        end
        q_ready = 1'b1;
        #1;
        tests++;
        if (psum_ready !== 1'b1) begin $display("FAIL bp_release_ready: got %0b required 1", psum_ready); fails++; end
        @(posedge clk); #1;
        psum_valid = 1'b0;
        tests++;
        if (q_valid !== 1'b1 || qlane(0) !== 8'd50 || busy !== 1'b0) begin
            $display("FAIL bp_swap: valid=%0b lane0=%h busy=%0b required 1/32/0", q_valid, qlane(0), busy); fails++;
        end
        @(posedge clk); #1;
        tests++;
        if (q_valid !== 1'b0) begin $display("FAIL bp_drop: got %0b required 0", q_valid); fails++; end
    endtask

    task automatic test_clear();
        setup(4, 0, 1'b0, 1'b1);
        set_lane(0, 1000);
        push_beat();
        push_beat();
        tests++;
        if (busy !== 1'b1) begin $display("FAIL clear_busy_before: got %0b required 1", busy); fails++; end
        acc_clear  = 1'b1;
        psum_valid = 1'b1;
        #1;
        tests++;
        if (psum_ready !== 1'b0) begin $display("FAIL clear_ready: got %0b required 0", psum_ready); fails++; end
        @(posedge clk); #1;
        acc_clear  = 1'b0;
        psum_valid = 1'b0;
        tests++;
        if (busy !== 1'b0 || q_valid !== 1'b0) begin
            $display("FAIL clear_after: busy=%0b valid=%0b required 0/0", busy, q_valid); fails++;
        end
        setup(1, 0, 1'b0, 1'b1);
        set_lane(0, 7);
        push_beat();
        tests++;
        if (q_valid !== 1'b1 || qlane(0) !== 8'd7) begin
            $display("FAIL clear_fresh_job: valid=%0b lane0=%h required 1/07", q_valid, qlane(0)); fails++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        setup(1, 0, 1'b0, 1'b0);
        set_lane(0, 9);
        push_beat();
        acc_len = 8'd3;
        set_lane(0, 1);
        push_beat();
        tests++;
        if (q_valid !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL areset_pre: valid=%0b busy=%0b required 1/1", q_valid, busy); fails++;
        end
        #3 reset = 1'b0;
        #1;
        tests++;
        if (q_valid !== 1'b0 || q_dout !== '0 || busy !== 1'b0) begin
            $display("FAIL areset_immediate: valid=%0b dout=%h busy=%0b required 0/0/0", q_valid, q_dout, busy); fails++;
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        setup(1, 0, 1'b0, 1'b1);
        set_lane(0, -9);
        push_beat();
        tests++;
        if (q_valid !== 1'b1 || qlane(0) !== 8'hF7) begin
            $display("FAIL areset_recover: valid=%0b lane0=%h required 1/f7", q_valid, qlane(0)); fails++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_multi_beat();
        test_rounding();
        test_sat_relu();
        test_back_to_back();
        test_backpressure();
        test_clear();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
